tlp_req_arbiter: RTL and testbench

Arbitrates between the AXI write-decode request stream (memory writes) and the AXI read-decode request stream (memory reads). Forwards one request per cycle to the shared TLP builder. Gates each grant on PCIe transmit flow-control credits: posted header (PH), posted data (PD) and non-posted header (NPH). Assigns a rolling tag to reads. Sits between the two decoders and the TLP builder.

---
 rtl/tlp_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_tlp_req_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_req_arbiter.sv
// Round-robin write/read request arbiter feeding the TLP builder.
// Grants are gated on PH/PD/NPH transmit credits; reads get rolling tags.
module tlp_req_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int CHUNK_MAX_BEATS = 4,
  parameter int TAG_WIDTH       = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [7:0]                            wr_length,
  input  logic [15:0]                           wr_bdf,
  input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] wr_wdata,
  input  logic                                  rd_valid,
  output logic                                  rd_ready,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  input  logic [7:0]                            rd_length,
  input  logic [15:0]                           rd_bdf,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ADDR_WIDTH-1:0]                 out_addr,
  output logic [7:0]                            out_length,
  output logic [15:0]                           out_bdf,
  output logic                                  out_is_memwrite,
  output logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] out_wdata,
  output logic [TAG_WIDTH-1:0]                  out_tag,
  input  logic                                  cr_ret_valid,
  input  logic [7:0]                            cr_ret_ph,
  input  logic [11:0]                           cr_ret_pd,
  input  logic [7:0]                            cr_ret_nph,
  output logic [7:0]                            cr_ph_avail,
  output logic [11:0]                           cr_pd_avail,
  output logic [7:0]                            cr_nph_avail,
  output logic                                  cr_overflow
);

  localparam int PW = DATA_WIDTH * CHUNK_MAX_BEATS;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_prio_wr;
  logic [TAG_WIDTH-1:0]  r_tag_ctr;
  logic [7:0]            r_ph;
  logic [11:0]           r_pd;
  logic [7:0]            r_nph;
  logic                  r_ovf;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [15:0]           r_bdf;
  logic                  r_is_wr;
  logic [PW-1:0]         r_wdata;
  logic [TAG_WIDTH-1:0]  r_tag;

  logic [8:0]            w_pd_need;
  logic                  w_grant_ok;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;
  logic                  w_gnt;
  logic [8:0]            w_ph_sum;
  logic [12:0]           w_pd_sum;
  logic [8:0]            w_nph_sum;

  // Eligibility and round-robin choice; an ineligible side never blocks.
  always_comb begin
    w_pd_need  = ({1'b0, wr_length} + 9'd3) >> 2;
    w_grant_ok = (r_state == S_EMPTY) || out_ready;
    w_wr_elig  = wr_valid && (r_ph != 8'd0) &&
                 ({3'b000, w_pd_need} <= r_pd);
    w_rd_elig  = rd_valid && (r_nph != 8'd0);
    w_gnt_wr   = w_grant_ok && w_wr_elig &&
                 (r_prio_wr || !w_rd_elig);
    w_gnt_rd   = w_grant_ok && w_rd_elig && !w_gnt_wr;
    w_gnt      = w_gnt_wr || w_gnt_rd;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_gnt) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (w_gnt)          w_state_nxt = S_FULL;
        else if (out_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // One bit wider than each counter so a return past all-ones is visible.
  always_comb begin
    w_ph_sum  = {1'b0, r_ph} - {8'd0, w_gnt_wr};
    w_pd_sum  = {1'b0, r_pd} -
                (w_gnt_wr ? {4'd0, w_pd_need} : 13'd0);
    w_nph_sum = {1'b0, r_nph} - {8'd0, w_gnt_rd};
    if (cr_ret_valid) begin
      w_ph_sum  = w_ph_sum + {1'b0, cr_ret_ph};
      w_pd_sum  = w_pd_sum + {1'b0, cr_ret_pd};
      w_nph_sum = w_nph_sum + {1'b0, cr_ret_nph};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph  <= 8'd0;
      r_pd  <= 12'd0;
      r_nph <= 8'd0;
      r_ovf <= 1'b0;
    end else begin
      r_ph  <= w_ph_sum[8]   ? 8'hFF   : w_ph_sum[7:0];
      r_pd  <= w_pd_sum[12]  ? 12'hFFF : w_pd_sum[11:0];
      r_nph <= w_nph_sum[8]  ? 8'hFF   : w_nph_sum[7:0];
      r_ovf <= r_ovf | w_ph_sum[8] | w_pd_sum[12] | w_nph_sum[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_wr <= 1'b1;
      r_tag_ctr <= '0;
      r_addr    <= '0;
      r_len     <= 8'd0;
      r_bdf     <= 16'd0;
      r_is_wr   <= 1'b0;
      r_wdata   <= '0;
      r_tag     <= '0;
    end else begin
      unique case (1'b1)
        w_gnt_wr: begin
          r_prio_wr <= 1'b0;
          r_addr    <= wr_addr;
          r_len     <= wr_length;
          r_bdf     <= wr_bdf;
          r_is_wr   <= 1'b1;
          r_wdata   <= wr_wdata;
          r_tag     <= '0;
        end
        w_gnt_rd: begin
          r_prio_wr <= 1'b1;
          r_addr    <= rd_addr;
          r_len     <= rd_length;
          r_bdf     <= rd_bdf;
          r_is_wr   <= 1'b0;
          r_wdata   <= '0;
          r_tag     <= r_tag_ctr;
          r_tag_ctr <= r_tag_ctr + TAG_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_ready        = w_gnt_wr;
  assign rd_ready        = w_gnt_rd;
  assign out_valid       = (r_state == S_FULL);
  assign out_addr        = r_addr;
  assign out_length      = r_len;
  assign out_bdf         = r_bdf;
  assign out_is_memwrite = r_is_wr;
  assign out_wdata       = r_wdata;
  assign out_tag         = r_tag;
  assign cr_ph_avail     = r_ph;
  assign cr_pd_avail     = r_pd;
  assign cr_nph_avail    = r_nph;
  assign cr_overflow     = r_ovf;

endmodule

// File: tb/tb_tlp_req_arbiter.sv
// Directed scoreboard bench for tlp_req_arbiter.
// Expected grants are queued at drive time and popped at the output.
module tb_tlp_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int CB = 4;
  localparam int TW = 5;
  localparam int PW = DW * CB;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_length;
  logic [15:0]   wr_bdf;
  logic [PW-1:0] wr_wdata;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_length;
  logic [15:0]   rd_bdf;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_length;
  logic [15:0]   out_bdf;
  logic          out_is_memwrite;
  logic [PW-1:0] out_wdata;
  logic [TW-1:0] out_tag;
  logic          cr_ret_valid;
  logic [7:0]    cr_ret_ph;
  logic [11:0]   cr_ret_pd;
  logic [7:0]    cr_ret_nph;
  logic [7:0]    cr_ph_avail;
  logic [11:0]   cr_pd_avail;
  logic [7:0]    cr_nph_avail;
  logic          cr_overflow;

  tlp_req_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CHUNK_MAX_BEATS(CB),
    .TAG_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_length(wr_length),
    .wr_bdf(wr_bdf),
    .wr_wdata(wr_wdata),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_addr(rd_addr),
    .rd_length(rd_length),
    .rd_bdf(rd_bdf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_length(out_length),
    .out_bdf(out_bdf),
    .out_is_memwrite(out_is_memwrite),
    .out_wdata(out_wdata),
    .out_tag(out_tag),
    .cr_ret_valid(cr_ret_valid),
    .cr_ret_ph(cr_ret_ph),
    .cr_ret_pd(cr_ret_pd),
    .cr_ret_nph(cr_ret_nph),
    .cr_ph_avail(cr_ph_avail),
    .cr_pd_avail(cr_pd_avail),
    .cr_nph_avail(cr_nph_avail),
    .cr_overflow(cr_overflow)
  );

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [15:0]   bdf;
    logic [TW-1:0] tag;
    logic [PW-1:0] wdata;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] exp_tag;
  logic [AW-1:0] a_addr;
  logic [7:0]    a_len;
  logic [PW-1:0] a_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [PW-1:0] rnd();
    logic [PW-1:0] d;
    for (int k = 0; k < PW / 32; k++)
      d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk();
    exp_t e;
    chk("out_valid", out_valid, 1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow got 0 exp 1");
    end else begin
      e = sb.pop_front();
      chk("is_wr", out_is_memwrite, e.is_wr);
      chk("addr", out_addr, e.addr);
      chk("len", out_length, e.len);
      chk("bdf", out_bdf, e.bdf);
      chk("tag", out_tag, e.tag);
      chk("wdata", out_wdata === e.wdata, 1);
    end
  endtask

  // Inputs are driven at posedge+1; readies settle and are checked
  // at posedge+2, the output is checked at the next posedge+1.
  task automatic step(input logic exp_w, input logic exp_r);
    exp_t e;
    #1;
    chk("wr_ready", wr_ready, exp_w);
    chk("rd_ready", rd_ready, exp_r);
    if (exp_w) begin
      e.is_wr = 1'b1; e.addr = wr_addr; e.len = wr_length;
      e.bdf = wr_bdf; e.tag = '0; e.wdata = wr_wdata;
      sb.push_back(e);
    end
    if (exp_r) begin
      e.is_wr = 1'b0; e.addr = rd_addr; e.len = rd_length;
      e.bdf = rd_bdf; e.tag = exp_tag; e.wdata = '0;
      sb.push_back(e);
      exp_tag = exp_tag + TW'(1);
    end
    @(posedge clk);
    #1;
    if (exp_w || exp_r) pop_chk();
  endtask

  task automatic ret(input logic [7:0] ph,
                     input logic [11:0] pd,
                     input logic [7:0] nph);
    cr_ret_valid = 1'b1;
    cr_ret_ph = ph; cr_ret_pd = pd; cr_ret_nph = nph;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_length = 8'd0;
    wr_bdf = 16'd0; wr_wdata = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_length = 8'd0; rd_bdf = 16'd0;
    out_ready = 1'b1;
    cr_ret_valid = 1'b0; cr_ret_ph = 8'd0;
    cr_ret_pd = 12'd0; cr_ret_nph = 8'd0;
    exp_tag = '0;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_ph", cr_ph_avail, 0);
    chk("rst_pd", cr_pd_avail, 0);
    chk("rst_nph", cr_nph_avail, 0);
    chk("rst_ovf", cr_overflow, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_is_wr", out_is_memwrite, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First credit advertisement; no grant until it registers
    wr_valid = 1'b1; wr_addr = 32'h1000_0000; wr_length = 8'd32;
    wr_bdf = 16'h0100; wr_wdata = rnd();
    ret(8'd4, 12'd16, 8'd2);
    step(0, 0);
    cr_ret_valid = 1'b0;
    chk("init_ph", cr_ph_avail, 4);
    chk("init_pd", cr_pd_avail, 16);
    chk("init_nph", cr_nph_avail, 2);
    step(1, 0);
    chk("w32_ph", cr_ph_avail, 3);
    chk("w32_pd", cr_pd_avail, 8);

    wr_addr = 32'h1000_0100; wr_length = 8'd16; wr_wdata = rnd();
    step(1, 0);
    chk("w16_pd", cr_pd_avail, 4);

    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 32'h2000_0000; rd_length = 8'd8;
    rd_bdf = 16'h0200;
    step(0, 1);

    // Write lacks PD while prio points to writes: read must pass it
    wr_valid = 1'b1; wr_addr = 32'h1000_0200; wr_length = 8'd32;
    wr_wdata = rnd();
    rd_addr = 32'h2000_0040;
    step(0, 1);
    chk("starve_pd", cr_pd_avail, 4);
    chk("starve_nph", cr_nph_avail, 0);
    rd_valid = 1'b0;
    ret(8'd0, 12'd4, 8'd0);
    step(0, 0);
    cr_ret_valid = 1'b0;
    chk("ret_pd", cr_pd_avail, 8);
    step(1, 0);
    chk("pd_zero", cr_pd_avail, 0);
    chk("ph_one", cr_ph_avail, 1);

    wr_valid = 1'b0;
    ret(8'd100, 12'd1000, 8'd100);
    step(0, 0);
    cr_ret_valid = 1'b0;
    chk("ample_ph", cr_ph_avail, 101);
    chk("ample_pd", cr_pd_avail, 1000);

    // Both sides held valid: strict alternation, read first here
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_length = 8'd4; rd_length = 8'd1;
    for (int i = 0; i < 70; i++) begin
      wr_addr = 32'h3000_0000 + 32'(i * 64);
      rd_addr = 32'h4000_0000 + 32'(i * 64);
      wr_bdf = 16'(i); rd_bdf = 16'(i + 1000);
      wr_wdata = rnd();
      step(i % 2 == 1, i % 2 == 0);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("alt_ph", cr_ph_avail, 66);
    chk("alt_pd", cr_pd_avail, 965);
    chk("alt_nph", cr_nph_avail, 65);

    // Back-pressure hold
    wr_valid = 1'b1; wr_addr = 32'h5000_0000; wr_length = 8'd8;
    wr_wdata = rnd();
    a_addr = wr_addr; a_len = wr_length; a_wdata = wr_wdata;
    step(1, 0);
    out_ready = 1'b0;
    wr_addr = 32'h5000_1000; wr_length = 8'd4; wr_wdata = rnd();
    rd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_wr_ready", wr_ready, 0);
      chk("hold_rd_ready", rd_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_addr", out_addr, a_addr);
      chk("hold_len", out_length, a_len);
      chk("hold_wdata", out_wdata === a_wdata, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; rd_valid = 1'b0;
    step(1, 0);
    wr_valid = 1'b0;
    step(0, 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_keep_addr", out_addr, 32'h5000_1000);

    // Asynchronous reset while FULL
    rd_valid = 1'b1; rd_addr = 32'h6000_0000;
    step(0, 1);
    rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ph", cr_ph_avail, 0);
    chk("arst_pd", cr_pd_avail, 0);
    chk("arst_nph", cr_nph_avail, 0);
    chk("arst_tag", out_tag, 0);
    exp_tag = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    wr_valid = 1'b1; wr_addr = 32'h7000_0000; wr_length = 8'd4;
    wr_wdata = rnd();
    rd_valid = 1'b1; rd_addr = 32'h7100_0000;
    step(0, 0);
    step(0, 0);
    ret(8'd1, 12'd100, 8'd1);
    step(0, 0);
    cr_ret_valid = 1'b0;
    chk("post_rst_ph", cr_ph_avail, 1);
    // Write first after reset; PH consume and return in one cycle
    ret(8'd2, 12'd0, 8'd0);
    step(1, 0);
    cr_ret_valid = 1'b0;
    chk("ph_same_cyc", cr_ph_avail, 2);
    chk("pd_after", cr_pd_avail, 99);
    step(0, 1);
    chk("nph_after", cr_nph_avail, 0);
    wr_valid = 1'b0; rd_valid = 1'b0;

    ret(8'd248, 12'd0, 8'd0);
    step(0, 0);
    cr_ret_valid = 1'b0;
    chk("ph_250", cr_ph_avail, 250);
    chk("ovf_clear", cr_overflow, 0);
    ret(8'd10, 12'd0, 8'd0);
    step(0, 0);
    cr_ret_valid = 1'b0;
    chk("ph_sat", cr_ph_avail, 255);
    chk("ovf_set", cr_overflow, 1);
    step(0, 0);
    chk("ovf_sticky", cr_overflow, 1);
    chk("sb_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
